// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch flush, memory wait, halt.
// Optional perf counters enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        EX_IsLoad,
  input  logic [4:0]  EX_Rd,
  input  logic        EX_BranchTaken,
  input  logic        MEM_Req,
  input  logic        MEM_Ready,
  input  logic        WB_IsHalt,
  output logic        PC_Enable,
  output logic        IFID_Enable,
  output logic        IDEX_Enable,
  output logic        EXMEM_Enable,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        MEMWB_Flush,
  output logic        Halted,
  output logic        Error,
  output logic [31:0] StallCycles,
  output logic [15:0] FlushCount
);

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_RUN,
    S_MEMWAIT,
    S_HALT,
    S_ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_stall;
  logic       load_use;
  logic       active;

  // Hazard detection and memory-stall qualification
  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_MEMWAIT);
    load_use  = EX_IsLoad && (EX_Rd != 5'd0) &&
                ((ID_UsesRs && (ID_Rs == EX_Rd)) ||
                 (ID_UsesRt && (ID_Rt == EX_Rd)));
    mem_stall = 1'b0;
    if (state_q == S_MEMWAIT) begin
      mem_stall = !MEM_Ready;
    end else if (state_q == S_RUN) begin
      mem_stall = MEM_Req && !MEM_Ready;
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state: a wait that hits the timeout traps in ERROR
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_RUN, S_MEMWAIT: begin
        if (mem_stall) begin
          wait_d  = (state_q == S_RUN) ? 8'd1 : wait_q + 8'd1;
          state_d = (wait_d >= TIMEOUT) ? S_ERROR : S_MEMWAIT;
        end else begin
          wait_d  = '0;
          state_d = WB_IsHalt ? S_HALT : S_RUN;
        end
      end
      default: begin
        wait_d = '0;
      end
    endcase
  end

  // Control outputs; freeze always beats flush on the same register
  always_comb begin
    PC_Enable    = 1'b0;
    IFID_Enable  = 1'b0;
    IDEX_Enable  = 1'b0;
    EXMEM_Enable = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    MEMWB_Flush  = 1'b0;
    priority case (1'b1)
      (state_q == S_ERROR): begin
        MEMWB_Flush = 1'b1;
      end
      (state_q == S_HALT): begin
        MEMWB_Flush = 1'b0;
      end
      mem_stall: begin
        MEMWB_Flush = 1'b1;
      end
      EX_BranchTaken: begin
        PC_Enable    = 1'b1;
        IFID_Enable  = 1'b1;
        IDEX_Enable  = 1'b1;
        EXMEM_Enable = 1'b1;
        IFID_Flush   = 1'b1;
        IDEX_Flush   = 1'b1;
      end
      load_use: begin
        IDEX_Enable  = 1'b1;
        EXMEM_Enable = 1'b1;
        IDEX_Flush   = 1'b1;
      end
      default: begin
        PC_Enable    = 1'b1;
        IFID_Enable  = 1'b1;
        IDEX_Enable  = 1'b1;
        EXMEM_Enable = 1'b1;
      end
    endcase
  end

  assign Halted = (state_q == S_HALT);
  assign Error  = (state_q == S_ERROR);

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Stall counter wraps; flush counter saturates
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active && !PC_Enable) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (IFID_Flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  logic unused_active;
  assign unused_active = active;
  assign StallCycles   = '0;
  assign FlushCount    = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with a per-cycle reference model.
// Runs with MEM_TIMEOUT=4; honours PIPELINE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

  localparam int TO = 4;
`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rd;
  logic        ID_UsesRs, ID_UsesRt, EX_IsLoad;
  logic        EX_BranchTaken, MEM_Req, MEM_Ready, WB_IsHalt;
  logic        PC_Enable, IFID_Enable, IDEX_Enable, EXMEM_Enable;
  logic        IFID_Flush, IDEX_Flush, MEMWB_Flush;
  logic        Halted, Error;
  logic [31:0] StallCycles;
  logic [15:0] FlushCount;

  always #5 clock = ~clock;

  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_IsLoad(EX_IsLoad), .EX_Rd(EX_Rd),
    .EX_BranchTaken(EX_BranchTaken),
    .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .WB_IsHalt(WB_IsHalt),
    .PC_Enable(PC_Enable), .IFID_Enable(IFID_Enable),
    .IDEX_Enable(IDEX_Enable), .EXMEM_Enable(EXMEM_Enable),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .MEMWB_Flush(MEMWB_Flush),
    .Halted(Halted), .Error(Error),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // {PC, IFID_en, IDEX_en, EXMEM_en, IFID_fl, IDEX_fl, MEMWB_fl}
  function automatic logic [6:0] ctl();
    return {PC_Enable, IFID_Enable, IDEX_Enable, EXMEM_Enable,
            IFID_Flush, IDEX_Flush, MEMWB_Flush};
  endfunction

  task automatic lit(input string name, input logic [6:0] e);
    chk(name, {57'd0, ctl()}, {57'd0, e});
  endtask

  // reference model state
  bit      m_wait, m_halt, m_err;
  int      m_cnt;
  longint  m_stall;
  int      m_flush;

  always @(negedge clock) begin
    logic [6:0] e;
    bit sm, lu;
    if (!reset) begin
      m_wait = 0; m_halt = 0; m_err = 0; m_cnt = 0;
      m_stall = 0; m_flush = 0;
    end
    sm = !m_err && !m_halt &&
         (m_wait ? !MEM_Ready : (MEM_Req && !MEM_Ready));
    lu = EX_IsLoad && EX_Rd != 0 &&
         ((ID_UsesRs && ID_Rs == EX_Rd) || (ID_UsesRt && ID_Rt == EX_Rd));
    if (m_err)               e = 7'b0000001;
    else if (m_halt)         e = 7'b0000000;
    else if (sm)             e = 7'b0000001;
    else if (EX_BranchTaken) e = 7'b1111110;
    else if (lu)             e = 7'b0011010;
    else                     e = 7'b1111000;
    chk("model_ctl", {57'd0, ctl()}, {57'd0, e});
    chk("model_halted", {63'd0, Halted}, {63'd0, m_halt});
    chk("model_error", {63'd0, Error}, {63'd0, m_err});
    chk("model_stalls", {32'd0, StallCycles},
        PERF ? {32'd0, m_stall[31:0]} : 64'd0);
    chk("model_flushes", {48'd0, FlushCount},
        PERF ? 64'(m_flush) : 64'd0);
    if (reset) begin
      if (!m_err && !m_halt && !e[6]) m_stall++;
      if (e[2] && m_flush < 65535) m_flush++;
      if (!m_err && !m_halt) begin
        if (sm) begin
          m_cnt = m_wait ? m_cnt + 1 : 1;
          if (m_cnt >= TO) begin
            m_err = 1; m_wait = 0;
          end else begin
            m_wait = 1;
          end
        end else begin
          m_wait = 0; m_cnt = 0;
          if (WB_IsHalt) m_halt = 1;
        end
      end
    end
  end

  task automatic idle();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    EX_IsLoad = 0; EX_Rd = 0; EX_BranchTaken = 0;
    MEM_Req = 0; MEM_Ready = 0; WB_IsHalt = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] s0;

  initial begin
    idle();
    reset = 1'b0;
    #1;
    chk("rst_halted", {63'd0, Halted}, 64'd0);
    chk("rst_error", {63'd0, Error}, 64'd0);
    chk("rst_stall", {32'd0, StallCycles}, 64'd0);
    chk("rst_flush", {48'd0, FlushCount}, 64'd0);
    tick(); tick();
    reset = 1'b1;
    #1 lit("run_idle", 7'b1111000);
    tick();
    // load-use on Rs, then load leaves EX
    EX_IsLoad = 1; EX_Rd = 5; ID_Rs = 5; ID_UsesRs = 1;
    #1 lit("lu_rs", 7'b0011010);
    tick();
    EX_IsLoad = 0;
    #1 lit("lu_after", 7'b1111000);
    tick();
    idle(); EX_IsLoad = 1; EX_Rd = 7; ID_Rs = 7; ID_Rt = 7; ID_UsesRt = 1;
    #1 lit("lu_rt", 7'b0011010);
    tick();
    idle(); EX_IsLoad = 1; EX_Rd = 9; ID_Rs = 9; ID_Rt = 3; ID_UsesRt = 1;
    #1 lit("lu_unused_src", 7'b1111000);
    tick();
    idle(); EX_IsLoad = 1; EX_Rd = 0; ID_Rs = 0; ID_UsesRs = 1;
    #1 lit("lu_rd0", 7'b1111000);
    tick();
    idle(); EX_IsLoad = 1; EX_Rd = 5; ID_Rs = 5; ID_UsesRs = 1;
    EX_BranchTaken = 1;
    #1 lit("lu_branch", 7'b1111110);
    tick();
    idle(); EX_BranchTaken = 1;
    #1 lit("branch", 7'b1111110);
    tick();
    // three wait cycles then ready: last cycle before timeout
    idle(); s0 = StallCycles; MEM_Req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 lit("memwait", 7'b0000001);
      tick();
    end
    MEM_Ready = 1;
    #1 lit("mem_ready", 7'b1111000);
    tick();
    idle();
    #1 chk("stall_delta", {32'd0, StallCycles - s0}, PERF ? 64'd3 : 64'd0);
    chk("no_err_3wait", {63'd0, Error}, 64'd0);
    tick();
    // halt request while stalled is ignored
    MEM_Req = 1; WB_IsHalt = 1;
    for (int i = 0; i < 2; i++) begin
      #1 lit("memwait_halt", 7'b0000001);
      tick();
    end
    MEM_Ready = 1; WB_IsHalt = 0;
    #1 lit("mem_ready2", 7'b1111000);
    tick();
    idle();
    #1 chk("no_halt_in_wait", {63'd0, Halted}, 64'd0);
    tick();
    MEM_Req = 1; MEM_Ready = 1;
    #1 lit("mem_hit", 7'b1111000);
    tick();
    // timeout after exactly TO wait cycles
    idle(); MEM_Req = 1;
    for (int i = 0; i < TO; i++) begin
      #1 lit("to_wait", 7'b0000001);
      tick();
    end
    #1 chk("to_error", {63'd0, Error}, 64'd1);
    lit("to_ctl", 7'b0000001);
    MEM_Ready = 1;
    tick();
    #1 chk("err_sticky", {63'd0, Error}, 64'd1);
    reset = 1'b0;
    #1 chk("rst_clears_err", {63'd0, Error}, 64'd0);
    tick();
    reset = 1'b1; idle();
    #1 lit("run_after_err", 7'b1111000);
    tick();
    // reset in the middle of a wait
    MEM_Req = 1;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; MEM_Req = 0;
    #1 lit("run_after_wait_rst", 7'b1111000);
    tick();
    MEM_Req = 1;
    tick(); tick(); tick();
    MEM_Ready = 1;
    #1 lit("wait_after_rst_ok", 7'b1111000);
    tick();
    // halt
    idle(); WB_IsHalt = 1;
    #1 lit("halt_req", 7'b1111000);
    tick();
    WB_IsHalt = 0; EX_BranchTaken = 1;
    #1 chk("halted", {63'd0, Halted}, 64'd1);
    lit("halt_branch", 7'b0000000);
    tick();
    idle(); MEM_Req = 1;
    #1 lit("halt_mem", 7'b0000000);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; idle();
    #1 chk("halt_cleared", {63'd0, Halted}, 64'd0);
    // a burst of branches for the flush counter
    for (int i = 0; i < 5; i++) begin
      EX_BranchTaken = (i % 2 == 0);
      tick();
    end
    idle();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max MEMWAIT cycles before error (range 1..255).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports ID_UsesRs, ID_UsesRt  input  1 each  source actually read.
REQ-006 SHALL have ports EX_IsLoad  input  1, EX_Rd  input  5  load in EX and its destination.
REQ-007 SHALL have port EX_BranchTaken  input  1  branch/jump resolved taken in EX.
REQ-008 SHALL have ports MEM_Req  input  1, MEM_Ready  input  1  data-memory access handshake.
REQ-009 SHALL have port WB_IsHalt  input  1  halt instruction retiring in WB.
REQ-010 SHALL have outputs PC_Enable, IFID_Enable, IDEX_Enable, EXMEM_Enable  1 each  register load enables.
REQ-011 SHALL have outputs IFID_Flush, IDEX_Flush, MEMWB_Flush  1 each  load a bubble (all-zero) instead of data.
REQ-012 SHALL have outputs Halted, Error  1 each  status; StallCycles  output  32, FlushCount  output  16  perf counters.

Function
REQ-013 SHALL implement FSM states RUN, MEMWAIT, HALT, ERROR; control outputs combinational from state and inputs (0-cycle latency).
REQ-014 RUN, no event: all enables 1, all flushes 0.
REQ-015 RUN, MEM_Req=1 and MEM_Ready=0: all enables 0, MEMWB_Flush=1, next state MEMWAIT, wait counter cleared to 1.
REQ-016 MEMWAIT, MEM_Ready=0: same outputs as REQ-015, wait counter increments; counter reaching MEM_TIMEOUT -> ERROR.
REQ-017 MEMWAIT, MEM_Ready=1: outputs as RUN (pipeline advances this cycle), next state RUN; MEM_Ready has priority over timeout in the same cycle.
REQ-018 Load-use hazard = EX_IsLoad & EX_Rd!=0 & ((ID_UsesRs & ID_Rs==EX_Rd) | (ID_UsesRt & ID_Rt==EX_Rd)); in RUN: PC_Enable=0, IFID_Enable=0, IDEX_Flush=1, rest as RUN; one cycle only.
REQ-019 EX_BranchTaken in RUN: PC_Enable=1, IFID_Flush=1, IDEX_Flush=1, enables 1.
REQ-020 Priority SHALL be: ERROR > HALT > memory wait > branch > load-use; branch suppresses a simultaneous load-use stall.
REQ-021 WB_IsHalt=1 in RUN or MEMWAIT with no memory stall this cycle: next state HALT; HALT/ERROR sticky until reset.
REQ-022 HALT: all enables 0, all flushes 0, Halted=1; ERROR: all enables 0, MEMWB_Flush=1, Error=1.
REQ-023 Flush asserted simultaneously with enable=0 on same register SHALL NOT occur (freeze wins in memory wait).

Reset
REQ-024 reset=0 SHALL immediately force state RUN, wait counter 0, StallCycles 0, FlushCount 0, Halted 0, Error 0.
REQ-025 Reset mid-MEMWAIT or in HALT/ERROR SHALL abandon the wait; first cycle after release behaves as RUN.

Configuration
REQ-026 With PIPELINE_CTRL_PERF_EN defined: StallCycles increments (wrap at 2^32) each cycle PC_Enable=0 in RUN/MEMWAIT; FlushCount increments (saturate at 16'hFFFF) each cycle IFID_Flush=1.
REQ-027 Without PIPELINE_CTRL_PERF_EN: StallCycles and FlushCount tied to 0, no counter flops.

Verification
REQ-028 EX_IsLoad=1, EX_Rd=5, ID_Rs=5, ID_UsesRs=1 -> 1 cycle PC_Enable=0, IFID_Enable=0, IDEX_Flush=1; next cycle (EX_IsLoad=0) all enables 1.
REQ-029 Same hazard with EX_Rd=0 -> no stall; same hazard plus EX_BranchTaken=1 -> IFID_Flush=1, IDEX_Flush=1, PC_Enable=1.
REQ-030 MEM_Req=1, MEM_Ready=0 for 3 cycles then 1 -> 3 cycles all enables 0, MEMWB_Flush=1, 4th cycle RUN outputs; StallCycles=3 with PERF_EN.
REQ-031 MEM_TIMEOUT=4, MEM_Ready held 0 -> ERROR after 4 wait cycles, Error=1 until reset=0; reset releases to RUN.
REQ-032 WB_IsHalt=1 -> next cycle Halted=1, all enables 0; EX_BranchTaken=1 while halted -> no flush.
